score_bcd_scanner: RTL and testbench

SCORE_BCD_SCANNER -- requirements
Module: score_bcd_scanner

---
 rtl/score_bcd_scanner_if.sv | 11 +
 rtl/score_bcd_scanner.sv | 179 +++++++++++++++++
 tb/tb_score_bcd_scanner.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/score_bcd_scanner_if.sv
// Conversion handshake between the game control FSM and the score BCD scanner.
interface score_bcd_scanner_if;
    logic [7:0]  score;
    logic        update;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    modport master (output score, output update, input busy, input done, input bcd);
    modport slave  (input score, input update, output busy, output done, output bcd);
endinterface

// File: rtl/score_bcd_scanner.sv
// Binary score to BCD (double-dabble) converter with a 3-digit multiplexed 7-segment scanner.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module score_bcd_scanner #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    score_bcd_scanner_if.slave         bus,
    input  logic                       show,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic [2:0]                 digit_en
);
    localparam int unsigned PW = 16;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [11:0] r_work, w_work_nxt;
    logic [11:0] w_adj;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        r_pend, w_pend_nxt;
    logic [7:0]  r_pend_val, w_pend_val_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic [11:0] r_bcd, w_bcd_nxt;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [6:0]    r_seg, w_seg_nxt;
    logic [2:0]    r_en, w_en_nxt;

    function automatic logic [11:0] dd_adjust(input logic [11:0] x);
        logic [11:0] y;
        y = x;
        for (int i = 0; i < 3; i++) begin
            if (x[i*4 +: 4] >= 4'd5) y[i*4 +: 4] = x[i*4 +: 4] + 4'd3;
        end
        return y;
    endfunction

    // Segment pattern g..a, active low
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign w_adj = dd_adjust(r_work);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_work     <= w_work_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_val <= w_pend_val_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_bcd      <= w_bcd_nxt;
        end
    end

    // A request arriving in LATCH wins over an older pending value
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_work_nxt     = r_work;
        w_cnt_nxt      = r_cnt;
        w_pend_nxt     = r_pend;
        w_pend_val_nxt = r_pend_val;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_bcd_nxt      = r_bcd;
        case (r_state)
            IDLE: begin
                if (bus.update) begin
                    w_shift_nxt = bus.score;
                    w_work_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_work_nxt  = {w_adj[10:0], r_shift[7]};
                w_shift_nxt = {r_shift[6:0], 1'b0};
                w_cnt_nxt   = r_cnt + 3'd1;
                if (r_cnt == 3'd7) w_state_nxt = LATCH;
                if (bus.update) begin
                    w_pend_nxt     = 1'b1;
                    w_pend_val_nxt = bus.score;
                end
            end
            LATCH: begin
                w_bcd_nxt  = r_work;
                w_done_nxt = 1'b1;
                if (r_pend || bus.update) begin
                    w_shift_nxt = bus.update ? bus.score : r_pend_val;
                    w_work_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = SHIFT;
                end else begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_seg   <= 7'b1111111;
            r_en    <= 3'b111;
        end else begin
            if (r_presc == PW'(SCAN_DIV - 1)) begin
                r_presc <= '0;
                r_idx   <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            r_seg <= w_seg_nxt;
            r_en  <= w_en_nxt;
        end
    end

    always_comb begin
        w_digit = 4'd0;
        case (r_idx)
            2'd0:    w_digit = r_bcd[3:0];
            2'd1:    w_digit = r_bcd[7:4];
            2'd2:    w_digit = r_bcd[11:8];
            default: w_digit = 4'd0;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = ((r_idx == 2'd2) && (r_bcd[11:8] == 4'd0)) ||
                  ((r_idx == 2'd1) && (r_bcd[11:4] == 8'd0));
`else
        w_blank = 1'b0;
`endif
        w_seg_nxt = (show && !w_blank) ? seg_decode(w_digit) : 7'b1111111;
        w_en_nxt  = show ? ~(3'b001 << r_idx) : 3'b111;
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;
    assign seg      = r_seg;
    assign digit_en = r_en;
    assign dp       = 1'b1;
endmodule

// File: tb/tb_score_bcd_scanner.sv
// Scoreboard bench for score_bcd_scanner: conversion latency/values, pending requests, scanning, reset.
module tb_score_bcd_scanner;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       show;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] digit_en;

    score_bcd_scanner_if bus ();

    score_bcd_scanner #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .show     (show),
        .seg      (seg),
        .dp       (dp),
        .digit_en (digit_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_pat(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Every done pulse must match the oldest expected conversion
    always @(negedge clk) begin
        if (bus.done) begin
            if (q.size() == 0) begin
                check("unexpected_done", {20'd0, bus.bcd}, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("bcd", {20'd0, bus.bcd}, {20'd0, e.bcd});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic pulse(input logic [7:0] v);
        @(negedge clk);
        bus.score  = v;
        bus.update = 1'b1;
        @(negedge clk);
        bus.update = 1'b0;
        last_n     = cyc;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic convert(input int v);
        exp_t e;
        pulse(8'(v));
        check("busy_next", {31'd0, bus.busy}, 32'd1);
        e.bcd = to_bcd(v);
        e.cyc = last_n + 9;
        q.push_back(e);
        drain();
        check("busy_after", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic scan_check(input logic [11:0] v);
        int t;
        logic [2:0]  en;
        logic [3:0]  d;
        logic [6:0]  s;
        t = 0;
        while (digit_en !== 3'b011 && t < 40) begin @(negedge clk); t++; end
        while (digit_en !== 3'b110 && t < 40) begin @(negedge clk); t++; end
        if (t >= 40) begin
            check("scan_sync_timeout", t, 0);
            return;
        end
        for (int i = 0; i < 12; i++) begin
            int k;
            k  = i / 4;
            en = ~(3'b001 << k);
            d  = v[k*4 +: 4];
            s  = seg_pat(d);
`ifdef LEADING_ZERO_BLANK_EN
            if ((k == 2 && v[11:8] == 4'd0) || (k == 1 && v[11:4] == 8'd0)) s = 7'b1111111;
`endif
            check("scan_en", {29'd0, digit_en}, {29'd0, en});
            check("scan_seg", {25'd0, seg}, {25'd0, s});
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        rst_n      = 1'b0;
        show       = 1'b1;
        bus.score  = '0;
        bus.update = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_bcd", {20'd0, bus.bcd}, 32'd0);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_en", {29'd0, digit_en}, 32'd7);
        check("rst_dp", {31'd0, dp}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        convert(255);
        convert(0);
        convert(9);
        convert(10);
        convert(99);
        convert(100);

        // 42 and 88 arrive during SHIFT of 17; only 88 survives
        pulse(8'd17);
        n     = last_n;
        e.bcd = to_bcd(17);
        e.cyc = n + 9;
        q.push_back(e);
        repeat (2) @(negedge clk);
        pulse(8'd42);
        pulse(8'd88);
        e.bcd = to_bcd(88);
        e.cyc = n + 18;
        q.push_back(e);
        drain();
        check("busy_after_pend", {31'd0, bus.busy}, 32'd0);

        // Request sampled in the LATCH cycle chains straight into SHIFT
        pulse(8'd50);
        n     = last_n;
        e.bcd = to_bcd(50);
        e.cyc = n + 9;
        q.push_back(e);
        repeat (7) @(negedge clk);
        pulse(8'd201);
        e.bcd = to_bcd(201);
        e.cyc = n + 18;
        q.push_back(e);
        drain();

        convert(123);
        scan_check(12'h123);
        @(negedge clk);
        show = 1'b0;
        @(negedge clk);
        check("show0_en", {29'd0, digit_en}, 32'd7);
        check("show0_seg", {25'd0, seg}, 32'h7F);
        show = 1'b1;

        convert(9);
        scan_check(12'h009);

        // Reset during the 4th SHIFT cycle of 200 abandons the conversion
        pulse(8'd200);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_bcd", {20'd0, bus.bcd}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_seg", {25'd0, seg}, 32'h7F);
        check("midrst_en", {29'd0, digit_en}, 32'd7);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_bcd", {20'd0, bus.bcd}, 32'd0);
        convert(200);
        scan_check(12'h200);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
